eb1_uart_boot_ctrl: RTL and testbench
=====================================

EB1_UART_BOOT_CTRL -- requirements
Module: eb1_uart_boot_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT_DEF, default 16'd868, meaning baud divisor driven to the UART receiver.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, meaning word-address width of the program memory.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 24'd1000000, meaning the maximum idle gap between bytes inside a frame.
REQ-004 SHALL have port i_Clock, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, reset; it is synchronous and active-high.
REQ-006 SHALL have port i_Rx_DV, input, 1, one-cycle byte-valid pulse from the UART receiver.
REQ-007 SHALL have port i_Rx_Byte, input, 8, received byte, valid while i_Rx_DV=1.
REQ-008 SHALL have port o_Clks_Per_Bit, output, 16, constant CLKS_PER_BIT_DEF.
REQ-009 SHALL have port o_Mem_We, output, 1, write request.
REQ-010 SHALL have port o_Mem_Addr, output, ADDR_WIDTH, word address.
REQ-011 SHALL have port o_Mem_Wdata, output, 32, write data.
REQ-012 SHALL have port i_Mem_Ready, input, 1, write accept.
REQ-013 SHALL have port o_Core_Rst, output, 1, holds the core in reset (1) until the load succeeds.
REQ-014 SHALL have port o_Done, output, 1, load completed.
REQ-015 SHALL have port o_Err, output, 1, load failed.

Function
REQ-016 SHALL implement the frame: sync byte 0xA5, word count N (16-bit, LE, 2 bytes), N words of 4 bytes each (LE), then checksum byte (see REQ-030).
REQ-017 SHALL implement states SYNC, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR.
REQ-018 SYNC: SHALL ignore every byte except 0xA5, which moves to LEN_LO; LEN_LO then LEN_HI SHALL each consume one byte.
REQ-019 LEN_HI: N=0 SHALL go to CSUM (or to DONE when the checksum is compiled out); N>2^ADDR_WIDTH SHALL go to ERR; otherwise SHALL go to DATA with address 0.
REQ-020 DATA: SHALL shift bytes into a 32-bit register, LSB first; on the 4th byte it SHALL go to WRITE and assert o_Mem_We the next cycle.
REQ-021 WRITE: SHALL hold o_Mem_We, o_Mem_Addr and o_Mem_Wdata stable until i_Mem_Ready=1; on acceptance it SHALL deassert We the next cycle and increment the address.
REQ-022 After acceptance, SHALL return to DATA, or go to CSUM (or to DONE when the checksum is compiled out) after the Nth word.
REQ-023 An i_Rx_DV arriving while in WRITE (overrun) SHALL go to ERR.
REQ-024 In any state except SYNC, DONE and ERR, TIMEOUT_CYCLES cycles without i_Rx_DV SHALL go to ERR; the counter SHALL reset on each i_Rx_DV and on each state entry.
REQ-025 DONE: o_Done=1 and o_Core_Rst=0; SHALL ignore further bytes until reset.
REQ-026 ERR: o_Err=1 and o_Core_Rst=1; a byte 0xA5 SHALL clear o_Err and go to LEN_LO.
REQ-027 Simultaneous i_Rx_DV and timeout expiry SHALL give priority to the byte.

Reset
REQ-028 rst_i=1 SHALL set the state to SYNC and clear o_Mem_We, o_Mem_Addr, o_Mem_Wdata, the count, the checksum, the timeout counter, o_Done and o_Err, and set o_Core_Rst=1; this applies in every state, including mid-DATA and mid-WRITE.
REQ-029 o_Clks_Per_Bit SHALL be valid during reset.

Configuration
REQ-030 With macro UART_BOOT_CSUM_EN defined: SHALL keep an 8-bit running sum (mod 256) of all data bytes; CSUM consumes one byte; a match SHALL go to DONE and a mismatch to ERR.
REQ-031 Without UART_BOOT_CSUM_EN: SHALL have no CSUM state and no sum register, and the Nth write acceptance SHALL go directly to DONE.

Structure
REQ-032 Package eb1_uart_boot_pkg SHALL hold the state encoding and the constant SYNC_BYTE=8'hA5.
REQ-033 Sub-module eb1_boot_timeout SHALL contain the loadable idle counter (inputs: clear, enable; output: expired).

Verification
REQ-034 Bench SHALL send A5 02 00 78 56 34 12 EF BE AD DE 4C -> writes addr0=0x12345678 and addr1=0xDEADBEEF, then o_Done=1 and o_Core_Rst=0.
REQ-035 Bench SHALL send the same frame with checksum 4D -> o_Err=1, o_Core_Rst=1, o_Done=0; then resend the correct frame -> o_Done=1.
REQ-036 Bench SHALL hold i_Mem_Ready=0 for 5 cycles on word 0 -> o_Mem_We, addr and data stable for 5 cycles; a byte injected during the stall -> o_Err=1.
REQ-037 Bench SHALL send A5 01 00 78 then hold the line idle for TIMEOUT_CYCLES -> o_Err=1, with no write issued.
REQ-038 Bench SHALL send A5 00 00 00 -> o_Done=1 with zero writes; with UART_BOOT_CSUM_EN undefined, A5 00 00 -> o_Done=1.
REQ-039 Bench SHALL assert rst_i for 1 cycle after byte 2 of word 1 -> state SYNC, address 0, o_Mem_We=0, o_Core_Rst=1; a full reload then succeeds.

Source files
------------

// File: rtl/eb1_uart_boot_pkg.sv
// rtl/eb1_uart_boot_pkg.sv - state encoding and frame constants for the UART boot loader.
// Optional checksum stage is enabled by UART_BOOT_CSUM_EN.
package eb1_uart_boot_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
`ifdef UART_BOOT_CSUM_EN
    ST_CSUM   = 3'd5,
`endif
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  // Where the frame goes once the last word (or an empty payload) is through.
`ifdef UART_BOOT_CSUM_EN
  localparam state_t ST_POST_LOAD = ST_CSUM;
`else
  localparam state_t ST_POST_LOAD = ST_DONE;
`endif

endpackage

// File: rtl/eb1_boot_timeout.sv
// rtl/eb1_boot_timeout.sv - idle-gap counter; expires after TIMEOUT_CYCLES enabled cycles without a clear.
module eb1_boot_timeout #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [23:0] LAST = TIMEOUT_CYCLES - 24'd1;

  logic [23:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 24'd0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/eb1_uart_boot_ctrl.sv
// rtl/eb1_uart_boot_ctrl.sv - UART frame loader writing 32-bit words into program memory.
// Checksum byte is checked only when UART_BOOT_CSUM_EN is defined.
module eb1_uart_boot_ctrl
  import eb1_uart_boot_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT_DEF = 16'd868,
  parameter int          ADDR_WIDTH       = 14,
  parameter logic [23:0] TIMEOUT_CYCLES   = 24'd1000000
) (
  input  logic                  i_Clock,
  input  logic                  rst_i,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic [15:0]           o_Clks_Per_Bit,
  output logic                  o_Mem_We,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [31:0]           o_Mem_Wdata,
  input  logic                  i_Mem_Ready,
  output logic                  o_Core_Rst,
  output logic                  o_Done,
  output logic                  o_Err
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [15:0]           cnt_q, cnt_d;   // low length byte, then words still to write
  logic [1:0]            bidx_q, bidx_d;
  logic [15:0]           len_n;
  logic                  to_clear, to_enable, to_expired;
`ifdef UART_BOOT_CSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  assign len_n = {i_Rx_Byte, cnt_q[7:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
`ifdef UART_BOOT_CSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_SYNC, ST_ERR: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = ST_LEN_LO;
          addr_d  = '0;
          bidx_d  = 2'd0;
`ifdef UART_BOOT_CSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      ST_LEN_LO: begin
        if (i_Rx_DV) begin
          cnt_d   = {8'd0, i_Rx_Byte};
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (i_Rx_DV) begin
          cnt_d = len_n;
          if (len_n == 16'd0) begin
            state_d = ST_POST_LOAD;
          end else if ({17'd0, len_n} > MAX_WORDS) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
            addr_d  = '0;
          end
        end
      end
      ST_DATA: begin
        if (i_Rx_DV) begin
          data_d = {i_Rx_Byte, data_q[31:8]};
          bidx_d = bidx_q + 2'd1;
`ifdef UART_BOOT_CSUM_EN
          sum_d  = sum_q + i_Rx_Byte;
`endif
          if (bidx_q == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (i_Rx_DV) begin
          state_d = ST_ERR;
        end else if (i_Mem_Ready) begin
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? ST_POST_LOAD : ST_DATA;
        end
      end
`ifdef UART_BOOT_CSUM_EN
      ST_CSUM: begin
        if (i_Rx_DV) state_d = (i_Rx_Byte == sum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: ;
      default: state_d = ST_SYNC;
    endcase
    // A byte arriving in the expiry cycle wins over the timeout.
    if (!i_Rx_DV && to_expired) state_d = ST_ERR;
  end

  always_ff @(posedge i_Clock) begin
    if (rst_i) begin
      state_q <= ST_SYNC;
      addr_q  <= '0;
      data_q  <= 32'd0;
      cnt_q   <= 16'd0;
      bidx_q  <= 2'd0;
`ifdef UART_BOOT_CSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
`ifdef UART_BOOT_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign to_clear  = i_Rx_DV || (state_d != state_q);
  assign to_enable = (state_q != ST_SYNC) && (state_q != ST_DONE) && (state_q != ST_ERR);

  eb1_boot_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (i_Clock),
    .rst_i    (rst_i),
    .clear_i  (to_clear),
    .enable_i (to_enable),
    .expired_o(to_expired)
  );

  assign o_Clks_Per_Bit = CLKS_PER_BIT_DEF;
  assign o_Mem_We       = (state_q == ST_WRITE);
  assign o_Mem_Addr     = addr_q;
  assign o_Mem_Wdata    = data_q;
  assign o_Done         = (state_q == ST_DONE);
  assign o_Err          = (state_q == ST_ERR);
  assign o_Core_Rst     = (state_q != ST_DONE);

endmodule

// File: tb/tb_eb1_uart_boot_ctrl.sv
// tb/tb_eb1_uart_boot_ctrl.sv - directed and randomized frame checks against a byte-level loader model.
module tb_eb1_uart_boot_ctrl;

  localparam int          AW  = 4;
  localparam logic [23:0] TO  = 24'd300;
  localparam int          GAP = 16;

  logic        i_Clock = 1'b0;
  logic        rst_i = 1'b1;
  logic        i_Rx_DV = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'd0;
  logic [15:0] o_Clks_Per_Bit;
  logic        o_Mem_We;
  logic [AW-1:0] o_Mem_Addr;
  logic [31:0] o_Mem_Wdata;
  logic        i_Mem_Ready;
  logic        o_Core_Rst, o_Done, o_Err;

  int checks = 0;
  int errors = 0;
  logic [63:0] got_q[$];
  bit stall_all = 1'b0;
  bit rand_ready = 1'b0;
  int low_run = 0;

  eb1_uart_boot_ctrl #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Clock(i_Clock), .rst_i(rst_i), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Clks_Per_Bit(o_Clks_Per_Bit), .o_Mem_We(o_Mem_We), .o_Mem_Addr(o_Mem_Addr),
    .o_Mem_Wdata(o_Mem_Wdata), .i_Mem_Ready(i_Mem_Ready), .o_Core_Rst(o_Core_Rst),
    .o_Done(o_Done), .o_Err(o_Err)
  );

  always #5 i_Clock = ~i_Clock;

  // Memory side: drives ready for the coming edge and logs the writes it will accept.
  initial begin
    i_Mem_Ready = 1'b1;
    forever begin
      @(negedge i_Clock);
      if (stall_all) begin
        i_Mem_Ready = 1'b0;
      end else if (rand_ready && low_run < 3 && $urandom_range(0, 1) == 0) begin
        i_Mem_Ready = 1'b0;
        low_run++;
      end else begin
        i_Mem_Ready = 1'b1;
        low_run = 0;
      end
      if (o_Mem_We && i_Mem_Ready && !rst_i) got_q.push_back({32'(o_Mem_Addr), o_Mem_Wdata});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_Clock);
    rst_i = 1'b1;
    @(negedge i_Clock);
    rst_i = 1'b0;
    got_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge i_Clock);
    i_Rx_DV = 1'b1;
    i_Rx_Byte = b;
    @(negedge i_Clock);
    i_Rx_DV = 1'b0;
    repeat (gap) @(negedge i_Clock);
  endtask

  // Reference: a frame is sync, LE count, LE words, then the byte sum of the payload.
  task automatic send_frame(input logic [31:0] w[$], input logic [7:0] csum_delta);
    logic [7:0] sum;
    logic [31:0] word;
    int n;
    n = w.size();
    sum = 8'd0;
    send_byte(8'hA5, GAP);
    send_byte(n[7:0], GAP);
    send_byte(n[15:8], GAP);
    foreach (w[i]) begin
      word = w[i];
      for (int k = 0; k < 4; k++) begin
        sum = sum + word[8*k +: 8];
        send_byte(word[8*k +: 8], GAP);
      end
    end
    send_byte(sum + csum_delta, GAP);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] w[$]);
    int n;
    check({tag, "_count"}, 64'(got_q.size()), 64'(w.size()));
    n = (got_q.size() < w.size()) ? got_q.size() : w.size();
    for (int i = 0; i < n; i++)
      check({tag, "_write"}, got_q[i], {32'(i % (1 << AW)), w[i]});
  endtask

  task automatic check_end(input string tag, input bit exp_done);
    check({tag, "_done"}, 64'(o_Done), 64'(exp_done));
    check({tag, "_err"}, 64'(o_Err), 64'(!exp_done));
    check({tag, "_core_rst"}, 64'(o_Core_Rst), 64'(!exp_done));
  endtask

  initial begin
    logic [31:0] frame[$];
    logic [31:0] none[$];
    logic [31:0] stall_word;
    logic [7:0] delta;
    bit exp_done;
    int n;

    frame = '{32'h12345678, 32'hDEADBEEF};
    none = {};

    // Reset values, including the constant divisor while reset is held.
    repeat (2) @(negedge i_Clock);
    check("clks_in_reset", 64'(o_Clks_Per_Bit), 64'd868);
    check("core_rst_in_reset", 64'(o_Core_Rst), 64'd1);
    do_reset();
    check("rst_we", 64'(o_Mem_We), 64'd0);
    check("rst_addr", 64'(o_Mem_Addr), 64'd0);
    check("rst_wdata", 64'(o_Mem_Wdata), 64'd0);
    check("rst_done", 64'(o_Done), 64'd0);
    check("rst_err", 64'(o_Err), 64'd0);

    // Good two-word frame, then bytes after completion are ignored.
    send_frame(frame, 8'd0);
    check_writes("good", frame);
    check_end("good", 1'b1);
    send_byte(8'hA5, GAP);
    check("done_ignores", 64'(o_Done), 64'd1);

    // Bad checksum, then a clean resend.
    do_reset();
    send_frame(frame, 8'd1);
`ifdef UART_BOOT_CSUM_EN
    check_end("bad_csum", 1'b0);
`else
    check_end("bad_csum", 1'b1);
`endif
    got_q.delete();
    send_frame(frame, 8'd0);
    check("resend_done", 64'(o_Done), 64'd1);

    // Memory stall on word 0, then an overrun byte.
    do_reset();
    stall_all = 1'b1;
    stall_word = 32'hCAFE1234;
    send_byte(8'hA5, GAP);
    send_byte(8'h01, GAP);
    send_byte(8'h00, GAP);
    for (int k = 0; k < 4; k++) send_byte(stall_word[8*k +: 8], (k == 3) ? 0 : GAP);
    for (int c = 0; c < 5; c++) begin
      check("stall_we", 64'(o_Mem_We), 64'd1);
      check("stall_addr", 64'(o_Mem_Addr), 64'd0);
      check("stall_data", 64'(o_Mem_Wdata), 64'(stall_word));
      @(negedge i_Clock);
    end
    send_byte(8'h11, 2);
    check("overrun_err", 64'(o_Err), 64'd1);
    check("overrun_we", 64'(o_Mem_We), 64'd0);
    stall_all = 1'b0;
    repeat (3) @(negedge i_Clock);
    check("overrun_writes", 64'(got_q.size()), 64'd0);

    // Idle line mid-word.
    do_reset();
    send_byte(8'hA5, GAP);
    send_byte(8'h01, GAP);
    send_byte(8'h00, GAP);
    send_byte(8'h78, 0);
    repeat (int'(TO) - 10) @(negedge i_Clock);
    check("timeout_early", 64'(o_Err), 64'd0);
    repeat (20) @(negedge i_Clock);
    check("timeout_err", 64'(o_Err), 64'd1);
    check("timeout_core_rst", 64'(o_Core_Rst), 64'd1);
    check("timeout_writes", 64'(got_q.size()), 64'd0);

    // Empty payload.
    do_reset();
    send_byte(8'hA5, GAP);
    send_byte(8'h00, GAP);
    send_byte(8'h00, GAP);
`ifdef UART_BOOT_CSUM_EN
    send_byte(8'h00, GAP);
`endif
    check_end("empty", 1'b1);
    check("empty_writes", 64'(got_q.size()), 64'd0);

    // Reset in the middle of word 1, then a full reload.
    do_reset();
    send_byte(8'hA5, GAP);
    send_byte(8'h02, GAP);
    send_byte(8'h00, GAP);
    for (int k = 0; k < 6; k++) send_byte(8'(k + 1), GAP);
    do_reset();
    check("midrst_we", 64'(o_Mem_We), 64'd0);
    check("midrst_addr", 64'(o_Mem_Addr), 64'd0);
    check("midrst_core_rst", 64'(o_Core_Rst), 64'd1);
    check("midrst_err", 64'(o_Err), 64'd0);
    send_frame(frame, 8'd0);
    check_writes("reload", frame);
    check_end("reload", 1'b1);

    // Length bounds: 2^AW+1 rejected, 2^AW accepted.
    do_reset();
    send_byte(8'hA5, GAP);
    send_byte(8'((1 << AW) + 1), GAP);
    send_byte(8'h00, GAP);
    check("too_long_err", 64'(o_Err), 64'd1);
    do_reset();
    frame.delete();
    for (int i = 0; i < (1 << AW); i++) frame.push_back($urandom);
    send_frame(frame, 8'd0);
    check_writes("max_len", frame);
    check_end("max_len", 1'b1);

    // Random frames with random memory back-pressure and occasional corrupt checksum.
    rand_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      frame.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) frame.push_back($urandom);
      delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
`ifdef UART_BOOT_CSUM_EN
      exp_done = (delta == 8'd0);
`else
      exp_done = 1'b1;
`endif
      send_frame(frame, delta);
      check_writes("rand", frame);
      check_end("rand", exp_done);
    end
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
